to_lower_stream: RTL
====================

Name: to_lower_stream

Overview:
- Streaming ASCII lowercase converter; the inverse of the team's combinational toUpper block.
- Accepts one byte per cycle on a valid/ready input and forces 'A'..'Z' (65..90) to 'a'..'z' (97..122) by setting bit 5. All other bytes pass unchanged.
- A registered two-entry skid buffer decouples the upstream and downstream handshakes.
- Per-packet conversion counters feed the text-processing status path.

Parameters:
- CNT_W, 16, width of the conversion and byte counters; counters saturate at 2^CNT_W-1.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  conversion enable, sampled with each accepted input byte; 0 = pass-through.
- in_valid  input  1  input byte valid.
- in_ready  output  1  block can accept a byte; registered.
- in_data  input  8  input byte.
- in_last  input  1  last byte of packet.
- out_valid  output  1  output byte valid.
- out_ready  input  1  downstream accepts the byte.
- out_data  output  8  converted byte.
- out_last  output  1  last byte of packet, delayed with its byte.
- out_changed  output  1  this output byte was modified.
- pkt_conv  output  CNT_W  conversions in the most recently completed packet.
- total_bytes  output  CNT_W  output handshakes since reset, saturating.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Input handshake: a byte transfers when in_valid && in_ready on a rising clk edge.
- Output handshake: a byte transfers when out_valid && out_ready on a rising clk edge.
- Conversion is done at acceptance and stored with the byte:
  - is_upper = (in_data >= 65) && (in_data <= 90).
  - chg = en && is_upper.
  - Stored data = in_data | (chg << 5). Stored changed = chg. in_last is stored alongside.
- en is sampled per byte. Changing en mid-packet affects only bytes accepted afterwards.
- Storage is two entries: main (drives the outputs) and skid. States:
  - EMPTY: out_valid=0, in_ready=1. Accept -> ONE.
  - ONE: out_valid=1, in_ready=1.
    - Accept with no output handshake -> TWO (new byte goes to skid).
    - Output handshake with no accept -> EMPTY.
    - Both in the same cycle -> ONE, with the new byte loaded into main.
  - TWO: out_valid=1, in_ready=0. Output handshake -> ONE, skid moves to main. No input is accepted in TWO.
- Latency: a byte accepted at edge N is presented on the outputs after edge N (one cycle) when the block was EMPTY.
- Throughput: 1 byte/cycle when out_ready stays high.
- Ordering is strictly FIFO. No byte is dropped or duplicated under any ready/valid pattern.
- Outputs are stable while out_valid=1 and out_ready=0.
- in_ready depends only on state, never combinationally on out_ready.
- Counters update on output handshakes only:
  - run_conv (internal) += out_changed, saturating.
  - total_bytes += 1, saturating.
  - On a handshake with out_last=1: pkt_conv <= run_conv + out_changed (saturating), and run_conv <= 0 on the same edge.
  - pkt_conv holds its value until the next packet completes.
- Reset, including mid-operation:
  - State <= EMPTY; in-flight bytes are discarded.
  - out_valid=0, in_ready=1, out_data=0, out_last=0, out_changed=0.
  - pkt_conv=0, run_conv=0, total_bytes=0.
  - An input offered during the reset cycle is not accepted.
- Boundary values:
  - 64 '@' and 91 '[' are unchanged.
  - 65 and 90 are converted.
  - Bytes 193..218 (bit 7 set) are unchanged.
  - Lowercase input is unchanged with out_changed=0.

Test Plan:
- Reset, then stream "Hi@Z[" with in_last on '[', en=1, out_ready=1 -> out_data 104,105,64,122,91; out_changed 1,0,0,1,0; each byte one cycle after acceptance; pkt_conv=2; total_bytes=5.
- en=0, stream 65,97,90 -> output 65,97,90 unchanged; out_changed all 0.
- Hold out_ready=0 and offer 3 bytes (66,67,68) -> two accepted, in_ready=0 after the second; outputs frozen at 98. Release out_ready -> 98,99,100 in order, then in_ready=1.
- Full-rate stream of 256 bytes 0..255 with random out_ready back-pressure -> every output equals reference (b in 65..90 ? b+32 : b); count of out_changed = 26.
- Assert rst while in TWO mid-packet -> next cycle out_valid=0, in_ready=1, counters=0. A following 1-byte packet 'A' with last -> 97 and pkt_conv=1.
- CNT_W=4: send a 20-byte packet of 'Q' -> pkt_conv=15 (saturated), total_bytes=15, run_conv cleared after last.

Source files
------------

// File: rtl/to_lower_stream.sv
// Streaming ASCII lowercase converter with a two-entry skid buffer and
// saturating per-packet conversion / byte counters.
module to_lower_stream #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [7:0]       in_data,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [7:0]       out_data,
   output logic             out_last,
   output logic             out_changed,
   output logic [CNT_W-1:0] pkt_conv,
   output logic [CNT_W-1:0] total_bytes
);

   // state | meaning
   // EMPTY | no byte held; outputs idle, input open
   // ONE   | main holds a byte; input open
   // TWO   | main and skid both hold bytes; input closed
   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_ONE   = 2'd1,
      S_TWO   = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t     state;
   logic [7:0] skid_data;
   logic       skid_last;
   logic       skid_changed;

   logic       acc;
   logic       hs;
   logic       is_upper;
   logic       chg;
   logic [7:0] conv_data;

   logic [CNT_W-1:0] run_conv;
   logic [CNT_W-1:0] run_next;
   logic [CNT_W-1:0] total_next;

   assign acc       = in_valid && in_ready;
   assign hs        = out_valid && out_ready;
   assign is_upper  = (in_data >= 8'd65) && (in_data <= 8'd90);
   assign chg       = en && is_upper;
   assign conv_data = in_data | {2'b00, chg, 5'b00000};

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= S_EMPTY;
         out_valid    <= 1'b0;
         in_ready     <= 1'b1;
         out_data     <= 8'd0;
         out_last     <= 1'b0;
         out_changed  <= 1'b0;
         skid_data    <= 8'd0;
         skid_last    <= 1'b0;
         skid_changed <= 1'b0;
      end else begin
         case (state)
            S_EMPTY: begin
               if (acc) begin
                  out_data    <= conv_data;
                  out_last    <= in_last;
                  out_changed <= chg;
                  out_valid   <= 1'b1;
                  state       <= S_ONE;
               end
            end
            S_ONE: begin
               if (acc && !hs) begin
                  skid_data    <= conv_data;
                  skid_last    <= in_last;
                  skid_changed <= chg;
                  in_ready     <= 1'b0;
                  state        <= S_TWO;
               end else if (hs && !acc) begin
                  out_valid <= 1'b0;
                  state     <= S_EMPTY;
               end else if (acc && hs) begin
                  out_data    <= conv_data;
                  out_last    <= in_last;
                  out_changed <= chg;
               end
            end
            S_TWO: begin
               if (hs) begin
                  out_data    <= skid_data;
                  out_last    <= skid_last;
                  out_changed <= skid_changed;
                  in_ready    <= 1'b1;
                  state       <= S_ONE;
               end
            end
            default: begin
               state     <= S_EMPTY;
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
            end
         endcase
      end
   end

   // Running count including the byte now leaving; used for both the
   // mid-packet accumulate and the end-of-packet snapshot.
   always_comb begin
      run_next = run_conv;
      if (out_changed && (run_conv != CNT_MAX)) run_next = run_conv + CNT_W'(1);
      total_next = total_bytes;
      if (total_bytes != CNT_MAX) total_next = total_bytes + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         run_conv    <= '0;
         pkt_conv    <= '0;
         total_bytes <= '0;
      end else if (hs) begin
         total_bytes <= total_next;
         if (out_last) begin
            pkt_conv <= run_next;
            run_conv <= '0;
         end else begin
            run_conv <= run_next;
         end
      end
   end

endmodule
